cnn_input_pooler: RTL and testbench

Reads the centred 224×224 crop window of the captured frame from the shared frame buffer on clk24. It averages each 8×8 block into one 4-bit pixel and streams the resulting 28×28 image, in raster order, to the LeNet input memory. It sits beside the VGA output stage on the frame-buffer read side. Its `busy` output drives the VGA stage's `bound_doing` overlay input.

---
 rtl/cnn_input_pooler.sv | 222 ++++++++++++++++++++++
 tb/tb_cnn_input_pooler.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/cnn_input_pooler.sv
// Pools the centred crop of the frame buffer into a 28x28 image of 4-bit pixels,
// averaging each REC_WIDTH x REC_HEIGHT block and streaming results in raster order.
module cnn_input_pooler #(
    parameter int REC_WIDTH        = 8,
    parameter int REC_HEIGHT       = 8,
    parameter int CNN_INPUT_WIDTH  = 28,
    parameter int CNN_INPUT_HEIGHT = 28,
    parameter int hRez             = 640,
    parameter int vRez             = 480
) (
    input  logic        clk24,
    input  logic        rst_n,
    input  logic        start,
    output logic [18:0] frame_addr,
    input  logic [3:0]  frame_pixel,
    output logic        busy,
    output logic        out_valid,
    output logic [9:0]  out_addr,
    output logic [3:0]  out_data,
    output logic        done
);

    localparam int LEFT0 = hRez / 2 - (REC_WIDTH * CNN_INPUT_WIDTH) / 2;
    localparam int UP0   = vRez / 2 - (REC_HEIGHT * CNN_INPUT_HEIGHT) / 2;

    localparam int CW  = $clog2(REC_WIDTH);
    localparam int RW  = $clog2(REC_HEIGHT);
    localparam int BXW = $clog2(CNN_INPUT_WIDTH);
    localparam int BYW = $clog2(CNN_INPUT_HEIGHT);
    localparam int SW  = $clog2(REC_WIDTH * REC_HEIGHT);

    localparam logic [18:0] ADDR_IDLE  = 19'd1;
    localparam logic [18:0] ADDR_FIRST = 19'(UP0 * hRez + LEFT0);
    localparam logic [18:0] STEP_ROW   = 19'(hRez - REC_WIDTH + 1);
    localparam logic [18:0] BACK_BLOCK = 19'((REC_HEIGHT - 1) * hRez - 1);
    localparam logic [18:0] STEP_BROW  = 19'(hRez - REC_WIDTH * CNN_INPUT_WIDTH + 1);

    localparam logic [CW-1:0]  C_LAST  = CW'(REC_WIDTH - 1);
    localparam logic [RW-1:0]  R_LAST  = RW'(REC_HEIGHT - 1);
    localparam logic [BXW-1:0] BX_LAST = BXW'(CNN_INPUT_WIDTH - 1);
    localparam logic [BYW-1:0] BY_LAST = BYW'(CNN_INPUT_HEIGHT - 1);
    localparam logic [SW-1:0]  S_LAST  = SW'(REC_WIDTH * REC_HEIGHT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [18:0]    addr_q, addr_d;
    logic [CW-1:0]  c_q, c_d;
    logic [RW-1:0]  r_q, r_d;
    logic [BXW-1:0] bx_q, bx_d;
    logic [BYW-1:0] by_q, by_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           vld_p1_q, vld_p1_d;

    logic [SW-1:0]  smp_q, smp_d;
    logic [9:0]     blk_q, blk_d;
    logic [9:0]     acc_q, acc_d;
    logic [9:0]     sum_p1;
    logic           oval_q, oval_d;
    logic [9:0]     oaddr_q, oaddr_d;
    logic [3:0]     odata_q, odata_d;

    // Truncating average of a full block sum (divide by 64, no rounding).
    function automatic logic [3:0] pool_avg(input logic [9:0] s);
        logic [9:0] sh;
        sh = s >> 6;
        return sh[3:0];
    endfunction

    // Address generator and control FSM; addresses are stepped incrementally.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        c_d      = c_q;
        r_d      = r_q;
        bx_d     = bx_q;
        by_d     = by_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        vld_p1_d = (state_q == S_READ);
        unique case (state_q)
            S_IDLE: begin
                addr_d = ADDR_IDLE;
                if (start) begin
                    state_d = S_READ;
                    busy_d  = 1'b1;
                    addr_d  = ADDR_FIRST;
                    c_d     = '0;
                    r_d     = '0;
                    bx_d    = '0;
                    by_d    = '0;
                end
            end
            S_READ: begin
                if (c_q != C_LAST) begin
                    c_d    = c_q + CW'(1);
                    addr_d = addr_q + 19'd1;
                end else if (r_q != R_LAST) begin
                    c_d    = '0;
                    r_d    = r_q + RW'(1);
                    addr_d = addr_q + STEP_ROW;
                end else if (bx_q != BX_LAST) begin
                    c_d    = '0;
                    r_d    = '0;
                    bx_d   = bx_q + BXW'(1);
                    addr_d = addr_q - BACK_BLOCK;
                end else if (by_q != BY_LAST) begin
                    c_d    = '0;
                    r_d    = '0;
                    bx_d   = '0;
                    by_d   = by_q + BYW'(1);
                    addr_d = addr_q + STEP_BROW;
                end else begin
                    state_d = S_DRAIN;
                    addr_d  = ADDR_IDLE;
                end
            end
            S_DRAIN: begin
                addr_d = ADDR_IDLE;
                // Only the final block strobes while draining.
                if (oval_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            S_DONE: begin
                addr_d  = ADDR_IDLE;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                addr_d  = ADDR_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk24 or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            addr_q   <= ADDR_IDLE;
            c_q      <= '0;
            r_q      <= '0;
            bx_q     <= '0;
            by_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            vld_p1_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            c_q      <= c_d;
            r_q      <= r_d;
            bx_q     <= bx_d;
            by_q     <= by_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            vld_p1_q <= vld_p1_d;
        end
    end

    // Stage p1: frame_pixel arrives alongside vld_p1_q and is accumulated.
    assign sum_p1 = (smp_q == '0) ? 10'(frame_pixel) : acc_q + 10'(frame_pixel);

    always_comb begin
        acc_d   = acc_q;
        smp_d   = smp_q;
        blk_d   = blk_q;
        oval_d  = 1'b0;
        oaddr_d = oaddr_q;
        odata_d = odata_q;
        if (vld_p1_q) begin
            acc_d = sum_p1;
            smp_d = smp_q + SW'(1);
            if (smp_q == S_LAST) begin
                oval_d  = 1'b1;
                oaddr_d = blk_q;
                odata_d = pool_avg(sum_p1);
                blk_d   = blk_q + 10'd1;
            end
        end
        if (state_q == S_IDLE) begin
            smp_d = '0;
            blk_d = '0;
        end
    end

    always_ff @(posedge clk24 or negedge rst_n) begin
        if (!rst_n) begin
            smp_q   <= '0;
            blk_q   <= '0;
            oval_q  <= 1'b0;
            oaddr_q <= '0;
            odata_q <= '0;
        end else begin
            smp_q   <= smp_d;
            blk_q   <= blk_d;
            oval_q  <= oval_d;
            oaddr_q <= oaddr_d;
            odata_q <= odata_d;
        end
    end

    // Accumulator contents are reloaded on each block's first sample.
    always_ff @(posedge clk24) begin
        acc_q <= acc_d;
    end

    assign frame_addr = addr_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign out_valid  = oval_q;
    assign out_addr   = oaddr_q;
    assign out_data   = odata_q;

endmodule

// File: tb/tb_cnn_input_pooler.sv
// Directed bench for cnn_input_pooler: frame-buffer model, address/strobe/done timing,
// start-while-busy, reset mid-run and truncating average cases.
module tb_cnn_input_pooler;

    logic        clk24 = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [18:0] frame_addr;
    logic [3:0]  frame_pixel = 4'd0;
    logic        busy;
    logic        out_valid;
    logic [9:0]  out_addr;
    logic [3:0]  out_data;
    logic        done;

    cnn_input_pooler dut (
        .clk24       (clk24),
        .rst_n       (rst_n),
        .start       (start),
        .frame_addr  (frame_addr),
        .frame_pixel (frame_pixel),
        .busy        (busy),
        .out_valid   (out_valid),
        .out_addr    (out_addr),
        .out_data    (out_data),
        .done        (done)
    );

    always #5 clk24 = ~clk24;

    int tcyc    = 0;
    int t0      = 0;
    int mode    = 0;
    int mon_en  = 0;
    int nstrobe = 0;
    int ndone   = 0;
    int npass   = 0;
    int ntotal  = 0;

    task automatic check(input string tag, input int obs, input int exp);
        ntotal++;
        if (obs == exp) npass++;
        else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    endtask

    // Mode 0: uniform 0xA. Mode 1: block 0 left half 15, block 1 all 15, rest 0.
    function automatic logic [3:0] pix(input logic [18:0] a);
        int row, col;
        row = int'(a) / 640;
        col = int'(a) % 640;
        if (mode == 0) return 4'hA;
        if (row >= 128 && row <= 135 && col >= 208 && col <= 211) return 4'hF;
        if (row >= 128 && row <= 135 && col >= 216 && col <= 223) return 4'hF;
        return 4'h0;
    endfunction

    always @(posedge clk24) begin
        tcyc        <= tcyc + 1;
        frame_pixel <= pix(frame_addr);
    end

    always @(negedge clk24) begin
        int rel;
        if (mon_en != 0) begin
            rel = tcyc - t0;
            if (out_valid) begin
                check("strobe_cycle", rel, 66 + 64 * nstrobe);
                check("out_addr", int'(out_addr), nstrobe);
                if (mode == 0) check("out_data_uniform", int'(out_data), 10);
                else if (nstrobe == 0) check("out_data_half", int'(out_data), 7);
                else if (nstrobe == 1) check("out_data_full", int'(out_data), 15);
                else if (nstrobe == 2) check("out_data_zero", int'(out_data), 0);
                nstrobe++;
            end
            if (done) begin
                ndone++;
                check("done_cycle", rel, 50179);
                check("done_strobes", nstrobe, 784);
            end
            if (rel >= 1 && rel <= 8) check("addr_first_row", int'(frame_addr), 82127 + rel);
            if (rel == 9)     check("addr_row1", int'(frame_addr), 82768);
            if (rel == 64)    check("addr_read63", int'(frame_addr), 86615);
            if (rel == 65)    check("addr_read64", int'(frame_addr), 82136);
            if (rel == 1793)  check("addr_read1792", int'(frame_addr), 87248);
            if (rel == 50177) check("addr_after_last", int'(frame_addr), 1);
            if (rel == 1)     check("busy_start", int'(busy), 1);
            if (rel == 50178) check("busy_last_strobe", int'(busy), 1);
            if (rel == 50179) check("busy_at_done", int'(busy), 0);
        end
    end

    task automatic wait_rel(input int k);
        while (tcyc - t0 < k) begin
            @(posedge clk24);
            #1;
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_frame_addr"}, int'(frame_addr), 1);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_out_addr"}, int'(out_addr), 0);
        check({tag, "_out_data"}, int'(out_data), 0);
        check({tag, "_done"}, int'(done), 0);
    endtask

    initial begin
        // Power-on reset
        repeat (3) @(posedge clk24);
        @(negedge clk24);
        check_reset("rst");
        @(posedge clk24);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk24);
        #1;

        // Run 1: uniform frame with ignored start pulses at 10 and 50178
        mode = 0; nstrobe = 0; ndone = 0;
        t0 = tcyc; mon_en = 1; start = 1'b1;
        wait_rel(1);     start = 1'b0;
        wait_rel(10);    start = 1'b1;
        wait_rel(11);    start = 1'b0;
        wait_rel(50178); start = 1'b1;
        wait_rel(50179); start = 1'b0;
        wait_rel(50180); start = 1'b1;
        wait_rel(50181); start = 1'b0;
        check("run1_done_count", ndone, 1);

        // Run 2 began at run-1 cycle 50180; reset it at its cycle 20000
        t0 = tcyc - 1; nstrobe = 0; ndone = 0;
        wait_rel(20000);
        mon_en = 0;
        rst_n  = 1'b0;
        @(negedge clk24);
        check_reset("midrst");
        repeat (3) @(posedge clk24);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk24);
        #1;
        check("run2_no_done", ndone + int'(done), 0);

        // Run 3: averaging boundary blocks
        mode = 1; nstrobe = 0; ndone = 0;
        t0 = tcyc; mon_en = 1; start = 1'b1;
        wait_rel(1);   start = 1'b0;
        wait_rel(195);
        check("run3_strobes", nstrobe, 3);
        mon_en = 0;

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
